// File: rtl/azadi_rst_ctrl.sv
// Board-level reset sequencer: merges POR, debounced button and PLL lock into
// staged peripheral/core resets and records the last reset cause and event count.
module azadi_rst_ctrl #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned STRETCH_CYCLES  = 64,
   parameter int unsigned CORE_DELAY      = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       btn_rst_ni,
   input  logic       pll_locked_i,
   output logic       periph_rst_no,
   output logic       core_rst_no,
   output logic [1:0] rst_cause_o,
   output logic [7:0] rst_count_o
);

   localparam int unsigned DBC_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned CNT_MAX = (STRETCH_CYCLES > CORE_DELAY) ? STRETCH_CYCLES : CORE_DELAY;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [DBC_W-1:0] DBC_LIMIT    = DBC_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CORE_LAST    = CNT_W'(CORE_DELAY - 1);

   localparam logic [1:0] WAIT_LOCK  = 2'd0;
   localparam logic [1:0] STRETCH    = 2'd1;
   localparam logic [1:0] PERIPH_REL = 2'd2;
   localparam logic [1:0] RUN        = 2'd3;

   localparam logic [1:0] CAUSE_POR = 2'b01;
   localparam logic [1:0] CAUSE_BTN = 2'b10;
   localparam logic [1:0] CAUSE_PLL = 2'b11;

   logic [SYNC_STAGES-1:0] btn_sync;
   logic [SYNC_STAGES-1:0] lock_sync;
   logic                   btn_s;
   logic                   lock_s;

   logic [DBC_W-1:0] dbc_q;
   logic             press;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cause_q, cause_d;
   logic [7:0]       count_q, count_d;
   logic             periph_q, core_q;

   // Both async inputs enter through their own synchronizer chain only.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         btn_sync  <= '0;
         lock_sync <= '0;
      end else begin
         btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_rst_ni};
         lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
      end
   end

   assign btn_s  = btn_sync[SYNC_STAGES-1];
   assign lock_s = lock_sync[SYNC_STAGES-1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dbc_q <= '0;
      end else if (btn_s) begin
         dbc_q <= '0;
      end else if (dbc_q != DBC_LIMIT) begin
         dbc_q <= dbc_q + DBC_W'(1);
      end
   end

   // Saturated counter keeps press asserted while the button stays held.
   assign press = (dbc_q == DBC_LIMIT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      count_d = count_q;
      case (state_q)
         WAIT_LOCK: begin
            if (lock_s && btn_s) begin
               state_d = STRETCH;
               cnt_d   = '0;
            end
         end
         STRETCH: begin
            if (!lock_s || !btn_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STRETCH_LAST) begin
               state_d = PERIPH_REL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PERIPH_REL, RUN: begin
            // PLL loss takes priority over a simultaneous button press.
            if (!lock_s || press) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               cause_d = !lock_s ? CAUSE_PLL : CAUSE_BTN;
               if (count_q != 8'hFF) begin
                  count_d = count_q + 8'd1;
               end
            end else if (state_q == PERIPH_REL) begin
               if (cnt_q == CORE_LAST) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= WAIT_LOCK;
         cnt_q    <= '0;
         cause_q  <= CAUSE_POR;
         count_q  <= '0;
         periph_q <= 1'b0;
         core_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cause_q  <= cause_d;
         count_q  <= count_d;
         periph_q <= (state_d == PERIPH_REL) || (state_d == RUN);
         core_q   <= (state_d == RUN);
      end
   end

   assign periph_rst_no = periph_q;
   assign core_rst_no   = core_q;
   assign rst_cause_o   = cause_q;
   assign rst_count_o   = count_q;

endmodule

// File: tb/tb_azadi_rst_ctrl.sv
// Bench for azadi_rst_ctrl: directed scenarios plus random button/lock traffic,
// compared every cycle against a reference model built on good-sample run lengths.
module tb_azadi_rst_ctrl;

   localparam int S  = 2;
   localparam int D  = 8;
   localparam int ST = 4;
   localparam int CD = 3;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       btn_rst_ni;
   logic       pll_locked_i;
   logic       periph_rst_no;
   logic       core_rst_no;
   logic [1:0] rst_cause_o;
   logic [7:0] rst_count_o;

   int n_tests = 0;
   int n_fail  = 0;

   azadi_rst_ctrl #(
      .SYNC_STAGES(S),
      .DEBOUNCE_CYCLES(D),
      .STRETCH_CYCLES(ST),
      .CORE_DELAY(CD)
   ) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .btn_rst_ni(btn_rst_ni),
      .pll_locked_i(pll_locked_i),
      .periph_rst_no(periph_rst_no),
      .core_rst_no(core_rst_no),
      .rst_cause_o(rst_cause_o),
      .rst_count_o(rst_count_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: inputs delayed S samples, button low-run length, and a count
   // of consecutive good samples since the last reset event.
   bit         mq_b[$];
   bit         mq_l[$];
   bit         m_rel;
   int         m_seq;
   int         m_low;
   logic [1:0] m_cause;
   logic [7:0] m_count;

   task automatic model_reset();
      mq_b.delete();
      mq_l.delete();
      for (int i = 0; i < S; i++) begin
         mq_b.push_back(1'b0);
         mq_l.push_back(1'b0);
      end
      m_rel   = 1'b0;
      m_seq   = 0;
      m_low   = 0;
      m_cause = 2'b01;
      m_count = 8'd0;
   endtask

   task automatic model_step(input bit b, input bit l);
      bit bs, ls, press;
      bs = mq_b.pop_front();
      ls = mq_l.pop_front();
      mq_b.push_back(b);
      mq_l.push_back(l);
      press = (m_low >= D);
      m_low = bs ? 0 : m_low + 1;
      if (m_rel) begin
         if (!ls || press) begin
            m_rel   = 1'b0;
            m_seq   = 0;
            m_cause = !ls ? 2'b11 : 2'b10;
            if (m_count < 8'd255) m_count = m_count + 8'd1;
         end else begin
            m_seq = m_seq + 1;
         end
      end else if (ls && bs) begin
         m_seq = m_seq + 1;
         if (m_seq == 1 + ST) m_rel = 1'b1;
      end else begin
         m_seq = 0;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock with the given raw inputs; model and DUT compared on the falling edge.
   task automatic cyc(input bit b, input bit l);
      btn_rst_ni   = b;
      pll_locked_i = l;
      @(posedge clk_i);
      model_step(b, l);
      @(negedge clk_i);
      check("periph", 8'(periph_rst_no), 8'(m_rel));
      check("core", 8'(core_rst_no), 8'(m_rel && (m_seq >= 1 + ST + CD)));
      check("cause", 8'(rst_cause_o), 8'(m_cause));
      check("count", rst_count_o, m_count);
   endtask

   initial begin
      int fp, fc, fe;
      bit hit;
      bit rb, rl;
      int len;

      // 1: POR bring-up with button and lock already good
      rst_ni       = 1'b0;
      btn_rst_ni   = 1'b1;
      pll_locked_i = 1'b1;
      @(negedge clk_i);
      check("por_periph", 8'(periph_rst_no), 8'd0);
      check("por_core", 8'(core_rst_no), 8'd0);
      check("por_cause", 8'(rst_cause_o), 8'd1);
      check("por_count", rst_count_o, 8'd0);
      rst_ni = 1'b1;
      model_reset();
      fp = 0;
      fc = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc(1, 1);
         if (periph_rst_no && fp == 0) fp = i;
         if (core_rst_no && fc == 0) fc = i;
      end
      check("bringup_periph_edge", 8'(fp), 8'd7);
      check("bringup_core_edge", 8'(fc), 8'd10);

      // 2: one-cycle lock loss in RUN
      cyc(1, 0);
      fe = 0;
      for (int i = 2; i <= 14; i++) begin
         cyc(1, 1);
         if (!periph_rst_no && fe == 0) fe = i;
      end
      check("lockloss_edge", 8'(fe), 8'd3);
      check("lockloss_cause", 8'(rst_cause_o), 8'd3);
      check("lockloss_count", rst_count_o, 8'd1);
      check("lockloss_resequenced", 8'(core_rst_no), 8'd1);

      // 3: button glitch, then a real press held 20 cycles
      hit = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1);
         if (!periph_rst_no) hit = 1'b1;
      end
      for (int i = 0; i < 15; i++) begin
         cyc(1, 1);
         if (!periph_rst_no) hit = 1'b1;
      end
      check("glitch_ignored", 8'(hit), 8'd0);
      fe = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc(0, 1);
         if (!periph_rst_no && fe == 0) fe = i;
      end
      check("press_edge", 8'(fe), 8'd11);
      check("press_held", 8'(periph_rst_no), 8'd0);
      check("press_cause", 8'(rst_cause_o), 8'd2);
      check("press_count", rst_count_o, 8'd2);
      for (int i = 0; i < 14; i++) cyc(1, 1);
      check("press_released", 8'(core_rst_no), 8'd1);

      // 4: button fault, then lock drops mid-STRETCH
      for (int i = 0; i < 12; i++) cyc(0, 1);
      hit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1);
         if (periph_rst_no) hit = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0);
         if (periph_rst_no) hit = 1'b1;
      end
      check("abort_no_pulse", 8'(hit), 8'd0);
      check("abort_cause", 8'(rst_cause_o), 8'd2);
      check("abort_count", rst_count_o, 8'd3);
      for (int i = 0; i < 14; i++) cyc(1, 1);
      check("abort_released", 8'(core_rst_no), 8'd1);

      // 5: lock loss lands on the debounce-complete cycle
      fe = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc(0, (i < 9) ? 1'b1 : 1'b0);
         if (!periph_rst_no && fe == 0) fe = i;
      end
      check("simul_edge", 8'(fe), 8'd11);
      check("simul_cause", 8'(rst_cause_o), 8'd3);
      check("simul_count", rst_count_o, 8'd4);
      for (int i = 0; i < 14; i++) cyc(1, 1);
      check("simul_released", 8'(core_rst_no), 8'd1);

      // Random button/lock traffic
      for (int seg = 0; seg < 80; seg++) begin
         rb  = ($urandom_range(0, 3) != 0);
         rl  = ($urandom_range(0, 4) != 0);
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) cyc(rb, rl);
      end

      // 6: count saturation over 300 lock-loss events
      for (int i = 0; i < 14; i++) cyc(1, 1);
      for (int ev = 0; ev < 300; ev++) begin
         cyc(1, 0);
         for (int i = 0; i < 9; i++) cyc(1, 1);
      end
      check("sat_count", rst_count_o, 8'd255);
      check("sat_cause", 8'(rst_cause_o), 8'd3);

      // POR asserted while in PERIPH_REL
      cyc(1, 0);
      for (int i = 0; i < 7; i++) cyc(1, 1);
      check("midseq_periph_rel", 8'(periph_rst_no), 8'd1);
      check("midseq_core_held", 8'(core_rst_no), 8'd0);
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_periph", 8'(periph_rst_no), 8'd0);
      check("async_core", 8'(core_rst_no), 8'd0);
      check("async_cause", 8'(rst_cause_o), 8'd1);
      check("async_count", rst_count_o, 8'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      model_reset();
      for (int i = 0; i < 12; i++) cyc(1, 1);
      check("post_por_core", 8'(core_rst_no), 8'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
